// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the main-memory arbiter and its cache clients.
// Requester ids double as bit positions in the one-hot grant vector.
package mem_arbiter_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_e;
  typedef enum logic [1:0] {REQ_I = 2'd0, REQ_D = 2'd1, REQ_W = 2'd2} req_id_e;

  localparam int DEF_LINE_BITS = 128;
  localparam int DEF_ADDR_BITS = 32;

  function automatic int line_off_bits(input int line_bits);
    return $clog2(line_bits / 8);
  endfunction
endpackage

// File: rtl/mem_arbiter_if.sv
// Single-port memory bus between the arbiter (master) and main memory (slave).
interface mem_arbiter_if #(
  parameter int LINE_BITS = mem_arbiter_pkg::DEF_LINE_BITS,
  parameter int ADDR_BITS = mem_arbiter_pkg::DEF_ADDR_BITS
);
  logic                 mem_valid_o;
  logic                 mem_we_o;
  logic [ADDR_BITS-1:0] mem_addr_o;
  logic [LINE_BITS-1:0] mem_wdata_o;
  logic                 mem_ready_i;
  logic [LINE_BITS-1:0] mem_rdata_i;

  modport master (output mem_valid_o, mem_we_o, mem_addr_o, mem_wdata_o,
                  input  mem_ready_i, mem_rdata_i);
  modport slave  (input  mem_valid_o, mem_we_o, mem_addr_o, mem_wdata_o,
                  output mem_ready_i, mem_rdata_i);
endinterface

// File: rtl/mem_arb_select.sv
// Combinational requester select: W absolute, then D/I ordered by the
// last-served pointer (tie it to 0 for fixed D-over-I priority).
module mem_arb_select
  import mem_arbiter_pkg::*;
(
  input  logic       req_i_i,
  input  logic       req_d_i,
  input  logic       req_w_i,
  input  logic       last_d_i,
  output logic [2:0] gnt_o,
  output logic       gnt_vld_o
);
  always_comb begin
    gnt_o = '0;
    if (req_w_i)                             gnt_o[REQ_W] = 1'b1;
    else if (req_d_i && !(req_i_i && last_d_i)) gnt_o[REQ_D] = 1'b1;
    else if (req_i_i)                        gnt_o[REQ_I] = 1'b1;
    gnt_vld_o = req_i_i | req_d_i | req_w_i;
  end
endmodule

// File: rtl/mem_arbiter.sv
// I/D-cache fill and writeback arbiter onto one memory port, one transaction
// in flight. Define MEM_ARBITER_RR_EN for round-robin between D and I fills.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int LINE_BITS = DEF_LINE_BITS,
  parameter int ADDR_BITS = DEF_ADDR_BITS
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 req_i_i,
  input  logic [ADDR_BITS-1:0] req_i_addr_i,
  input  logic                 req_d_i,
  input  logic [ADDR_BITS-1:0] req_d_addr_i,
  input  logic                 req_w_i,
  input  logic [ADDR_BITS-1:0] req_w_addr_i,
  input  logic [LINE_BITS-1:0] req_w_data_i,
  output logic                 ack_i_o,
  output logic                 ack_d_o,
  output logic                 ack_w_o,
  output logic [LINE_BITS-1:0] fill_data_o,
  output logic                 busy_o,
  mem_arbiter_if.master        mem
);
  localparam int OFF = line_off_bits(LINE_BITS);

  state_e               state_q, state_d;
  req_id_e              id_q, id_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [LINE_BITS-1:0] wdata_q, wdata_d;
  logic [LINE_BITS-1:0] fill_q, fill_d;
  logic [2:0]           gnt;
  logic                 gnt_vld;
  logic                 last_d_q;

  mem_arb_select u_sel (
    .req_i_i  (req_i_i),
    .req_d_i  (req_d_i),
    .req_w_i  (req_w_i),
    .last_d_i (last_d_q),
    .gnt_o    (gnt),
    .gnt_vld_o(gnt_vld)
  );

`ifdef MEM_ARBITER_RR_EN
  // 1 = D served most recently; writebacks leave it alone.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                                           last_d_q <= 1'b0;
    else if (state_q == IDLE && gnt_vld && !gnt[REQ_W])   last_d_q <= gnt[REQ_D];
  end
`else
  assign last_d_q = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    fill_d  = fill_q;
    case (state_q)
      IDLE: if (gnt_vld) begin
        state_d = BUSY;
        if (gnt[REQ_W]) begin
          id_d    = REQ_W;
          addr_d  = {req_w_addr_i[ADDR_BITS-1:OFF], {OFF{1'b0}}};
          wdata_d = req_w_data_i;
        end else if (gnt[REQ_D]) begin
          id_d   = REQ_D;
          addr_d = {req_d_addr_i[ADDR_BITS-1:OFF], {OFF{1'b0}}};
        end else begin
          id_d   = REQ_I;
          addr_d = {req_i_addr_i[ADDR_BITS-1:OFF], {OFF{1'b0}}};
        end
      end
      BUSY: if (mem.mem_ready_i) begin
        state_d = RESP;
        if (id_q != REQ_W) fill_d = mem.mem_rdata_i;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      id_q    <= REQ_I;
      addr_q  <= '0;
      wdata_q <= '0;
      fill_q  <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      fill_q  <= fill_d;
    end
  end

  assign mem.mem_valid_o = (state_q == BUSY);
  assign mem.mem_we_o    = (state_q == BUSY) && (id_q == REQ_W);
  assign mem.mem_addr_o  = addr_q;
  assign mem.mem_wdata_o = wdata_q;
  assign ack_i_o         = (state_q == RESP) && (id_q == REQ_I);
  assign ack_d_o         = (state_q == RESP) && (id_q == REQ_D);
  assign ack_w_o         = (state_q == RESP) && (id_q == REQ_W);
  assign fill_data_o     = fill_q;
  assign busy_o          = (state_q != IDLE);
endmodule
